// File: rtl/relay_pulse_sequencer.sv
// Break-before-make pulse sequencer for four latching relays on H-bridges.
// Accepts one command at a time, drops and counts strobes while busy.
module relay_pulse_sequencer #(
  parameter int CLK_HZ      = 250000000,
  parameter int PULSE_US    = 10000,
  parameter int DEAD_CYC    = 250,
  parameter int COOLDOWN_US = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       relay_en,
  input  logic       relay_dir,
  input  logic [1:0] relay_channel,
  output logic       relay_done,
  output logic       busy,
  output logic [3:0] coil_a,
  output logic [3:0] coil_b,
  output logic [7:0] drop_count
);

  localparam int CYC_PER_US   = CLK_HZ / 1000000;
  localparam int PULSE_CYC    = CYC_PER_US * PULSE_US;
  localparam int COOLDOWN_CYC = CYC_PER_US * COOLDOWN_US;
  localparam int MAX_PC       = (PULSE_CYC > COOLDOWN_CYC) ? PULSE_CYC : COOLDOWN_CYC;
  localparam int MAX_CYC      = (MAX_PC > DEAD_CYC) ? MAX_PC : DEAD_CYC;
  localparam int CNT_W        = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] DEAD_LOAD  = CNT_W'(DEAD_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] COOL_LOAD  = CNT_W'((COOLDOWN_CYC > 0) ? COOLDOWN_CYC - 1 : 0);

  typedef enum logic [2:0] {
    IDLE,
    PRE_GUARD,
    PULSE,
    POST_GUARD,
    COOLDOWN,
    DONE
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             dir_reg, dir_next;
  logic [1:0]       ch_reg, ch_next;
  logic [7:0]       drop_reg, drop_next;
  logic [3:0]       coil_a_reg, coil_a_next;
  logic [3:0]       coil_b_reg, coil_b_next;
  logic             pulse_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      dir_reg    <= 1'b0;
      ch_reg     <= 2'd0;
      drop_reg   <= 8'd0;
      coil_a_reg <= 4'd0;
      coil_b_reg <= 4'd0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      dir_reg    <= dir_next;
      ch_reg     <= ch_next;
      drop_reg   <= drop_next;
      coil_a_reg <= coil_a_next;
      coil_b_reg <= coil_b_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    dir_next   = dir_reg;
    ch_next    = ch_reg;
    case (state_reg)
      IDLE: begin
        if (relay_en) begin
          dir_next   = relay_dir;
          ch_next    = relay_channel;
          cnt_next   = DEAD_LOAD;
          state_next = PRE_GUARD;
        end
      end
      PRE_GUARD: begin
        if (cnt_reg == '0) begin
          cnt_next   = PULSE_LOAD;
          state_next = PULSE;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      PULSE: begin
        if (cnt_reg == '0) begin
          cnt_next   = DEAD_LOAD;
          state_next = POST_GUARD;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      POST_GUARD: begin
        if (cnt_reg == '0) begin
          cnt_next   = COOL_LOAD;
          state_next = (COOLDOWN_CYC > 0) ? COOLDOWN : DONE;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      COOLDOWN: begin
        if (cnt_reg == '0) begin
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    drop_next = drop_reg;
    if (relay_en && (state_reg != IDLE) && (drop_reg != 8'hFF)) begin
      drop_next = drop_reg + 8'd1;
    end
  end

  // Coil drive is decoded from the next state so the registered legs switch
  // on the same edge the FSM enters or leaves PULSE.
  assign pulse_next = (state_next == PULSE);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_coil
      assign coil_a_next[gi] = pulse_next &&  dir_next && (ch_next == 2'(gi));
      assign coil_b_next[gi] = pulse_next && !dir_next && (ch_next == 2'(gi));
    end
  endgenerate

  // Bridge legs drop with rst itself, independent of flop clear-to-Q timing.
  assign coil_a     = rst ? 4'd0 : coil_a_reg;
  assign coil_b     = rst ? 4'd0 : coil_b_reg;
  assign busy       = (state_reg != IDLE);
  assign relay_done = (state_reg == DONE);
  assign drop_count = drop_reg;

endmodule

// File: tb/tb_relay_pulse_sequencer.sv
// Self-checking bench for relay_pulse_sequencer: table vectors, corner sequences
// and a randomized run against a timestamp-based reference model.
`timescale 1ns/1ps
module tb_relay_pulse_sequencer;

  localparam int CLK_HZ      = 1000000;
  localparam int PULSE_US    = 5;
  localparam int DEAD_CYC    = 2;
  localparam int COOLDOWN_US = 3;
  localparam int P = CLK_HZ / 1000000 * PULSE_US;
  localparam int D = DEAD_CYC;
  localparam int C = CLK_HZ / 1000000 * COOLDOWN_US;
  localparam int T_ON   = D + 1;
  localparam int T_OFF  = D + P;
  localparam int T_DONE = 2 * D + P + C + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       relay_en = 1'b0;
  logic       relay_dir = 1'b0;
  logic [1:0] relay_channel = 2'd0;
  logic       relay_done;
  logic       busy;
  logic [3:0] coil_a;
  logic [3:0] coil_b;
  logic [7:0] drop_count;

  relay_pulse_sequencer #(
    .CLK_HZ(CLK_HZ), .PULSE_US(PULSE_US), .DEAD_CYC(DEAD_CYC), .COOLDOWN_US(COOLDOWN_US)
  ) dut (
    .clk(clk), .rst(rst), .relay_en(relay_en), .relay_dir(relay_dir),
    .relay_channel(relay_channel), .relay_done(relay_done), .busy(busy),
    .coil_a(coil_a), .coil_b(coil_b), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int gcyc = 0;

  // Reference model: a command is a timestamp plus its latched dir/channel.
  bit         m_active = 1'b0;
  int         m_t0 = 0;
  logic       m_dir = 1'b0;
  logic [1:0] m_ch = 2'd0;
  int         m_drops = 0;

  logic [3:0] s_a, s_b;
  logic       s_busy, s_done;
  logic [7:0] s_drop;

  bit         mon_en = 1'b0;
  logic [7:0] mon_prev = 8'd0;
  int         mon_run = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, gcyc);
  endtask

  // One clock cycle: drive, sample on negedge, compare with model, advance model.
  task automatic cycle(input logic en, input logic dir, input logic [1:0] ch);
    logic       e_busy, e_done, e_on;
    logic [3:0] e_a, e_b;
    relay_en      = en;
    relay_dir     = dir;
    relay_channel = ch;
    @(negedge clk);
    s_a = coil_a; s_b = coil_b; s_busy = busy; s_done = relay_done; s_drop = drop_count;
    e_busy = m_active && (gcyc > m_t0);
    e_done = m_active && (gcyc == m_t0 + T_DONE);
    e_on   = m_active && (gcyc >= m_t0 + T_ON) && (gcyc <= m_t0 + T_OFF);
    e_a    = (e_on &&  m_dir) ? (4'd1 << m_ch) : 4'd0;
    e_b    = (e_on && !m_dir) ? (4'd1 << m_ch) : 4'd0;
    chk("model_coil_a", s_a, e_a);
    chk("model_coil_b", s_b, e_b);
    chk("model_busy", s_busy, e_busy);
    chk("model_done", s_done, e_done);
    chk("model_drop", s_drop, m_drops);
    @(posedge clk);
    if (e_done) m_active = 1'b0;
    if (en && !e_busy) begin
      m_active = 1'b1; m_t0 = gcyc; m_dir = dir; m_ch = ch;
      $display("cmd cycle %0d: ch=%0d dir=%0d accepted", gcyc, ch, dir);
    end else if (en) begin
      if (m_drops < 255) m_drops++;
    end
    gcyc++;
    #1;
  endtask

  // Coil invariants always; pulse width only during the randomized run.
  always @(negedge clk) begin
    logic [7:0] cur;
    int ones;
    cur  = {coil_a, coil_b};
    ones = $countones(coil_a | coil_b);
    chk("inv_ab_overlap", coil_a & coil_b, 4'd0);
    chk("inv_onehot", (ones <= 1), 1'b1);
    if (mon_en) begin
      if (cur != 8'd0 && cur == mon_prev) mon_run++;
      else begin
        if (mon_prev != 8'd0) chk("pulse_width", mon_run, P);
        mon_run = (cur != 8'd0) ? 1 : 0;
      end
      mon_prev = cur;
    end else begin
      mon_prev = 8'd0;
      mon_run  = 0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit (cycle %0d)", gcyc);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       dir;
    logic [1:0] ch;
    int         first;
    int         last;
    logic [3:0] ea;
    logic [3:0] eb;
    logic       ebusy;
    logic       edone;
  } vec_t;

  vec_t tab[12];

  initial begin
    logic [3:0] seen;
    int         base;

    tab[0]  = '{1'b1, 2'd2, 0,  0,  4'h0, 4'h0, 1'b0, 1'b0};
    tab[1]  = '{1'b1, 2'd2, 1,  2,  4'h0, 4'h0, 1'b1, 1'b0};
    tab[2]  = '{1'b1, 2'd2, 3,  7,  4'h4, 4'h0, 1'b1, 1'b0};
    tab[3]  = '{1'b1, 2'd2, 8,  12, 4'h0, 4'h0, 1'b1, 1'b0};
    tab[4]  = '{1'b1, 2'd2, 13, 13, 4'h0, 4'h0, 1'b1, 1'b1};
    tab[5]  = '{1'b1, 2'd2, 14, 15, 4'h0, 4'h0, 1'b0, 1'b0};
    tab[6]  = '{1'b0, 2'd0, 0,  0,  4'h0, 4'h0, 1'b0, 1'b0};
    tab[7]  = '{1'b0, 2'd0, 1,  2,  4'h0, 4'h0, 1'b1, 1'b0};
    tab[8]  = '{1'b0, 2'd0, 3,  7,  4'h0, 4'h1, 1'b1, 1'b0};
    tab[9]  = '{1'b0, 2'd0, 8,  12, 4'h0, 4'h0, 1'b1, 1'b0};
    tab[10] = '{1'b0, 2'd0, 13, 13, 4'h0, 4'h0, 1'b1, 1'b1};
    tab[11] = '{1'b0, 2'd0, 14, 15, 4'h0, 4'h0, 1'b0, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_coil_a", coil_a, 4'd0);
    chk("rst_coil_b", coil_b, 4'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", relay_done, 1'b0);
    chk("rst_drop", drop_count, 8'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Table vectors: set on ch2 and reset on ch0
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 16; r++) begin
        cycle(r == 0, (r == 0) ? tab[6*k].dir : 1'($urandom_range(0, 1)),
              (r == 0) ? tab[6*k].ch : 2'($urandom_range(0, 3)));
        for (int e = 6*k; e < 6*k + 6; e++) begin
          if (r >= tab[e].first && r <= tab[e].last) begin
            chk("tab_coil_a", s_a, tab[e].ea);
            chk("tab_coil_b", s_b, tab[e].eb);
            chk("tab_busy", s_busy, tab[e].ebusy);
            chk("tab_done", s_done, tab[e].edone);
          end
        end
      end
    end

    // Strobe while busy is dropped; then saturate the drop counter
    seen = 4'd0;
    for (int r = 0; r < 16; r++) begin
      cycle((r == 0) || (r == 4), 1'b1, (r == 4) ? 2'd1 : 2'd2);
      seen = seen | s_a | s_b;
    end
    chk("drop_one_ch1_idle", seen[1], 1'b0);
    chk("drop_one", s_drop, 8'd1);
    for (int r = 0; r < 320; r++) cycle(1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
    for (int r = 0; r < 20; r++) cycle(1'b0, 1'b0, 2'd0);
    chk("drop_saturate", s_drop, 8'hFF);

    // Reset mid-pulse aborts immediately with no relay_done
    for (int r = 0; r < 5; r++) cycle(r == 0, 1'b1, 2'd2);
    chk("abort_coil_before", coil_a, 4'b0100);
    #2 rst = 1'b1;
    #1;
    chk("abort_coil_a_async", coil_a, 4'd0);
    chk("abort_coil_b_async", coil_b, 4'd0);
    chk("abort_busy_async", busy, 1'b0);
    m_active = 1'b0;
    m_drops  = 0;
    @(posedge clk); @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    gcyc = gcyc + 4;
    for (int r = 0; r < 20; r++) cycle(1'b0, 1'b1, 2'd2);
    chk("abort_drop_cleared", s_drop, 8'd0);
    for (int r = 0; r < 16; r++) cycle(r == 0, 1'b1, 2'd3);

    // Back-to-back: accepted on the cycle after relay_done
    for (int r = 0; r < 32; r++) begin
      cycle((r == 0) || (r == 14), (r == 0), (r == 0) ? 2'd1 : 2'd3);
      if (r == 13) chk("b2b_done", s_done, 1'b1);
      if (r == 14) chk("b2b_idle", s_busy, 1'b0);
      if (r == 15) chk("b2b_busy", s_busy, 1'b1);
      if (r == 17) chk("b2b_coil_b", s_b, 4'b1000);
    end

    // Randomized commands against the model
    mon_en = 1'b1;
    for (int r = 0; r < 10000; r++)
      cycle($urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
    for (int r = 0; r < 20; r++) cycle(1'b0, 1'b0, 2'd0);
    mon_en = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
